// File: rtl/ysyx_22050133_axi_xbar.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050133_axi_xbar
// Function : AXI4 1-to-2 router (slave 0 = memory, slave 1 = CLINT) with
//            combinational forwarding and registered per-path route locks.
// Revision : 1.0
// ============================================================================
module ysyx_22050133_axi_xbar #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter logic [AXI_ADDR_WIDTH-1:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] CLINT_SIZE = 32'h0001_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    // upstream master port
    input  logic                        s_aw_valid,
    input  logic [AXI_ID_WIDTH-1:0]     s_aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_aw_addr,
    input  logic [7:0]                  s_aw_len,
    input  logic [2:0]                  s_aw_size,
    input  logic [1:0]                  s_aw_burst,
    output logic                        s_aw_ready,
    input  logic                        s_w_valid,
    input  logic [AXI_DATA_WIDTH-1:0]   s_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_w_strb,
    input  logic                        s_w_last,
    output logic                        s_w_ready,
    input  logic                        s_b_ready,
    output logic                        s_b_valid,
    output logic [AXI_ID_WIDTH-1:0]     s_b_id,
    output logic [1:0]                  s_b_resp,
    input  logic                        s_ar_valid,
    input  logic [AXI_ID_WIDTH-1:0]     s_ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_ar_addr,
    input  logic [7:0]                  s_ar_len,
    input  logic [2:0]                  s_ar_size,
    input  logic [1:0]                  s_ar_burst,
    output logic                        s_ar_ready,
    input  logic                        s_r_ready,
    output logic                        s_r_valid,
    output logic [AXI_ID_WIDTH-1:0]     s_r_id,
    output logic [1:0]                  s_r_resp,
    output logic [AXI_DATA_WIDTH-1:0]   s_r_data,
    output logic                        s_r_last,
    // downstream slave 0 (memory)
    output logic                        m0_aw_valid,
    output logic [AXI_ID_WIDTH-1:0]     m0_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0]   m0_aw_addr,
    output logic [7:0]                  m0_aw_len,
    output logic [2:0]                  m0_aw_size,
    output logic [1:0]                  m0_aw_burst,
    input  logic                        m0_aw_ready,
    output logic                        m0_w_valid,
    output logic [AXI_DATA_WIDTH-1:0]   m0_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] m0_w_strb,
    output logic                        m0_w_last,
    input  logic                        m0_w_ready,
    output logic                        m0_b_ready,
    input  logic                        m0_b_valid,
    input  logic [AXI_ID_WIDTH-1:0]     m0_b_id,
    input  logic [1:0]                  m0_b_resp,
    output logic                        m0_ar_valid,
    output logic [AXI_ID_WIDTH-1:0]     m0_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0]   m0_ar_addr,
    output logic [7:0]                  m0_ar_len,
    output logic [2:0]                  m0_ar_size,
    output logic [1:0]                  m0_ar_burst,
    input  logic                        m0_ar_ready,
    output logic                        m0_r_ready,
    input  logic                        m0_r_valid,
    input  logic [AXI_ID_WIDTH-1:0]     m0_r_id,
    input  logic [1:0]                  m0_r_resp,
    input  logic [AXI_DATA_WIDTH-1:0]   m0_r_data,
    input  logic                        m0_r_last,
    // downstream slave 1 (CLINT)
    output logic                        m1_aw_valid,
    output logic [AXI_ID_WIDTH-1:0]     m1_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0]   m1_aw_addr,
    output logic [7:0]                  m1_aw_len,
    output logic [2:0]                  m1_aw_size,
    output logic [1:0]                  m1_aw_burst,
    input  logic                        m1_aw_ready,
    output logic                        m1_w_valid,
    output logic [AXI_DATA_WIDTH-1:0]   m1_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] m1_w_strb,
    output logic                        m1_w_last,
    input  logic                        m1_w_ready,
    output logic                        m1_b_ready,
    input  logic                        m1_b_valid,
    input  logic [AXI_ID_WIDTH-1:0]     m1_b_id,
    input  logic [1:0]                  m1_b_resp,
    output logic                        m1_ar_valid,
    output logic [AXI_ID_WIDTH-1:0]     m1_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0]   m1_ar_addr,
    output logic [7:0]                  m1_ar_len,
    output logic [2:0]                  m1_ar_size,
    output logic [1:0]                  m1_ar_burst,
    input  logic                        m1_ar_ready,
    output logic                        m1_r_ready,
    input  logic                        m1_r_valid,
    input  logic [AXI_ID_WIDTH-1:0]     m1_r_id,
    input  logic [1:0]                  m1_r_resp,
    input  logic [AXI_DATA_WIDTH-1:0]   m1_r_data,
    input  logic                        m1_r_last
);

    localparam logic [AXI_ADDR_WIDTH-1:0] c_clint_end = CLINT_BASE + CLINT_SIZE;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    rd_state_e  r_rstate;
    logic       r_rsel;
    logic [7:0] r_rcnt;
    wr_state_e  r_wstate;
    logic       r_wsel;

    logic w_ar_sel, w_aw_sel;
    logic w_ar_open, w_r_open, w_aw_open, w_w_open, w_b_open;
    logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
    logic w_unused_r_last;

    // Slaves generate their own r_last, but the router's beat count is authoritative.
    assign w_unused_r_last = m0_r_last ^ m1_r_last;

    assign w_ar_sel = (s_ar_addr >= CLINT_BASE) && (s_ar_addr < c_clint_end);
    assign w_aw_sel = (s_aw_addr >= CLINT_BASE) && (s_aw_addr < c_clint_end);

    // Every valid/ready output is qualified by !rst so nothing leaks while in reset.
    assign w_ar_open = !rst && (r_rstate == R_IDLE);
    assign w_r_open  = !rst && (r_rstate == R_BUSY);
    assign w_aw_open = !rst && (r_wstate == W_IDLE);
    assign w_w_open  = !rst && (r_wstate == W_DATA);
    assign w_b_open  = !rst && (r_wstate == W_RESP);

    // Read address channel
    assign m0_ar_valid = w_ar_open && s_ar_valid && !w_ar_sel;
    assign m1_ar_valid = w_ar_open && s_ar_valid &&  w_ar_sel;
    assign s_ar_ready  = w_ar_open && (w_ar_sel ? m1_ar_ready : m0_ar_ready);
    assign m0_ar_id    = s_ar_id;
    assign m0_ar_addr  = s_ar_addr;
    assign m0_ar_len   = s_ar_len;
    assign m0_ar_size  = s_ar_size;
    assign m0_ar_burst = s_ar_burst;
    assign m1_ar_id    = s_ar_id;
    assign m1_ar_addr  = s_ar_addr;
    assign m1_ar_len   = s_ar_len;
    assign m1_ar_size  = s_ar_size;
    assign m1_ar_burst = s_ar_burst;

    // Read data channel
    assign s_r_valid  = w_r_open && (r_rsel ? m1_r_valid : m0_r_valid);
    assign s_r_id     = r_rsel ? m1_r_id   : m0_r_id;
    assign s_r_resp   = r_rsel ? m1_r_resp : m0_r_resp;
    assign s_r_data   = r_rsel ? m1_r_data : m0_r_data;
    assign s_r_last   = (r_rcnt == 8'd0);
    assign m0_r_ready = w_r_open && !r_rsel && s_r_ready;
    assign m1_r_ready = w_r_open &&  r_rsel && s_r_ready;

    // Write address channel
    assign m0_aw_valid = w_aw_open && s_aw_valid && !w_aw_sel;
    assign m1_aw_valid = w_aw_open && s_aw_valid &&  w_aw_sel;
    assign s_aw_ready  = w_aw_open && (w_aw_sel ? m1_aw_ready : m0_aw_ready);
    assign m0_aw_id    = s_aw_id;
    assign m0_aw_addr  = s_aw_addr;
    assign m0_aw_len   = s_aw_len;
    assign m0_aw_size  = s_aw_size;
    assign m0_aw_burst = s_aw_burst;
    assign m1_aw_id    = s_aw_id;
    assign m1_aw_addr  = s_aw_addr;
    assign m1_aw_len   = s_aw_len;
    assign m1_aw_size  = s_aw_size;
    assign m1_aw_burst = s_aw_burst;

    // Write data channel
    assign m0_w_valid = w_w_open && !r_wsel && s_w_valid;
    assign m1_w_valid = w_w_open &&  r_wsel && s_w_valid;
    assign s_w_ready  = w_w_open && (r_wsel ? m1_w_ready : m0_w_ready);
    assign m0_w_data  = s_w_data;
    assign m0_w_strb  = s_w_strb;
    assign m0_w_last  = s_w_last;
    assign m1_w_data  = s_w_data;
    assign m1_w_strb  = s_w_strb;
    assign m1_w_last  = s_w_last;

    // Write response channel
    assign s_b_valid  = w_b_open && (r_wsel ? m1_b_valid : m0_b_valid);
    assign s_b_id     = r_wsel ? m1_b_id   : m0_b_id;
    assign s_b_resp   = r_wsel ? m1_b_resp : m0_b_resp;
    assign m0_b_ready = w_b_open && !r_wsel && s_b_ready;
    assign m1_b_ready = w_b_open &&  r_wsel && s_b_ready;

    assign w_ar_hs = s_ar_valid && s_ar_ready;
    assign w_r_hs  = s_r_valid  && s_r_ready;
    assign w_aw_hs = s_aw_valid && s_aw_ready;
    assign w_w_hs  = s_w_valid  && s_w_ready;
    assign w_b_hs  = s_b_valid  && s_b_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rsel   <= 1'b0;
            r_rcnt   <= 8'd0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate <= R_BUSY;
                        r_rsel   <= w_ar_sel;
                        r_rcnt   <= s_ar_len;
                    end
                end
                R_BUSY: begin
                    if (w_r_hs) begin
                        if (r_rcnt == 8'd0) begin
                            r_rstate <= R_IDLE;
                        end else begin
                            r_rcnt <= r_rcnt - 8'd1;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_wsel   <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wstate <= W_DATA;
                        r_wsel   <= w_aw_sel;
                    end
                end
                W_DATA: begin
                    if (w_w_hs && s_w_last) begin
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
